// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control unit (Moore FSM).
// Sequences fetch/decode/execute/memory/writeback. Memory states wait on
// mem_ready, and a wait counter raises bus_err after MAX_WAIT idle cycles.
// Optional feature macro: MC_CONTROLLER_JAL_EN (adds jal with link writeback).
module mc_controller #(
  parameter int unsigned OP_W     = 6,
  parameter int unsigned FUNCT_W  = 6,
  parameter int unsigned ALUC_W   = 3,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [OP_W-1:0]   op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pcen,
  output logic              iord,
  output logic              irwrite,
  output logic              memwrite,
  output logic              memtoreg,
  output logic              regdst,
  output logic              regwrite,
  output logic              alusrca,
  output logic [1:0]        alusrcb,
  output logic [1:0]        pcsrc,
  output logic [ALUC_W-1:0] alucontrol,
  output logic              immext,
  output logic              link,
  output logic              illegal,
  output logic              bus_err
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
`ifdef MC_CONTROLLER_JAL_EN
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);
`endif

  localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] FN_SLT = FUNCT_W'(6'b101010);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTEXEC,
    S_RTWB,
    S_IEXEC,
    S_IWB,
    S_BRANCH,
    S_JUMP,
    S_JAL
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_st;
  logic             timeout;
  logic [2:0]       alu3;

  // State register and wait counter; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, wait-counter and Moore output decode.
  always_comb begin
    state_d  = state_q;
    pcen     = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    alu3     = ALU_AND;
    immext   = 1'b0;
    link     = 1'b0;
    illegal  = 1'b0;
    bus_err  = 1'b0;

    wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // A ready in the same cycle the count hits MAX_WAIT still counts as success.
    timeout = wait_st && !mem_ready && (cnt_q == CNT_W'(MAX_WAIT));

    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        alu3    = ALU_ADD;
        if (timeout) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end else if (mem_ready) begin
          irwrite = 1'b1;
          pcen    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        alu3    = ALU_ADD;
        if ((op == OP_LW) || (op == OP_SW)) begin
          state_d = S_MEMADR;
        end else if (op == OP_RTYPE) begin
          state_d = S_RTEXEC;
        end else if ((op == OP_BEQ) || (op == OP_BNE)) begin
          state_d = S_BRANCH;
        end else if ((op == OP_ADDI) || (op == OP_SLTI) ||
                     (op == OP_ANDI) || (op == OP_ORI)) begin
          state_d = S_IEXEC;
        end else if (op == OP_J) begin
          state_d = S_JUMP;
`ifdef MC_CONTROLLER_JAL_EN
        end else if (op == OP_JAL) begin
          state_d = S_JAL;
`endif
        end else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alu3    = ALU_ADD;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (timeout) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end else if (mem_ready) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        iord = 1'b1;
        if (timeout) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          memwrite = 1'b1;
          if (mem_ready) begin
            state_d = S_FETCH;
          end
        end
      end
      S_RTEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b00;
        case (funct)
          FN_ADD:  alu3 = ALU_ADD;
          FN_SUB:  alu3 = ALU_SUB;
          FN_AND:  alu3 = ALU_AND;
          FN_OR:   alu3 = ALU_OR;
          FN_SLT:  alu3 = ALU_SLT;
          default: begin
            alu3    = ALU_ADD;
            illegal = 1'b1;
          end
        endcase
        state_d = S_RTWB;
      end
      S_RTWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_SLTI) begin
          alu3 = ALU_SLT;
        end else if (op == OP_ANDI) begin
          alu3   = ALU_AND;
          immext = 1'b1;
        end else if (op == OP_ORI) begin
          alu3   = ALU_OR;
          immext = 1'b1;
        end else begin
          alu3 = ALU_ADD;
        end
        state_d = S_IWB;
      end
      S_IWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        alusrcb = 2'b00;
        alu3    = ALU_SUB;
        pcsrc   = 2'b01;
        pcen    = (op == OP_BNE) ? ~zero : zero;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        state_d = S_FETCH;
      end
`ifdef MC_CONTROLLER_JAL_EN
      S_JAL: begin
        pcsrc    = 2'b10;
        pcen     = 1'b1;
        regwrite = 1'b1;
        link     = 1'b1;
        state_d  = S_FETCH;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Counter restarts on every state entry (including FETCH re-entry on timeout).
    cnt_d = (wait_st && !mem_ready && !timeout) ? cnt_q + CNT_W'(1) : '0;

    // Enables are gated combinationally so an async reset kills them at once.
    if (!reset_n) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
      bus_err  = 1'b0;
    end

    alucontrol = ALUC_W'(alu3);
  end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-cycle expected output vectors
// are queued as stimulus is applied and popped when outputs are sampled.
module tb_mc_controller;

  localparam int unsigned MW = 15;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pcen, iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       immext, link, illegal, bus_err;

  always #5 clk = ~clk;

  mc_controller #(
    .OP_W(6), .FUNCT_W(6), .ALUC_W(3), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcen(pcen), .iord(iord), .irwrite(irwrite),
    .memwrite(memwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .immext(immext), .link(link), .illegal(illegal),
    .bus_err(bus_err)
  );

  typedef struct packed {
    logic       pcen, iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluc;
    logic       immext, link, illegal, bus_err;
  } outs_t;

  typedef struct {
    logic       rdy;
    logic       zr;
    logic [5:0] op;
    logic [5:0] fn;
    outs_t      e;
  } step_t;

  step_t plan[$];
  outs_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;

  // Expected output vectors per state, straight from the state table.
  function automatic outs_t o_fetch(input logic ok, input logic be);
    outs_t o = '0;
    o.alusrcb = 2'b01; o.aluc = 3'b010; o.irwrite = ok; o.pcen = ok; o.bus_err = be;
    return o;
  endfunction
  function automatic outs_t o_decode(input logic ill);
    outs_t o = '0;
    o.alusrcb = 2'b11; o.aluc = 3'b010; o.illegal = ill;
    return o;
  endfunction
  function automatic outs_t o_memadr();
    outs_t o = '0;
    o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluc = 3'b010;
    return o;
  endfunction
  function automatic outs_t o_memrd(input logic be);
    outs_t o = '0;
    o.iord = 1'b1; o.bus_err = be;
    return o;
  endfunction
  function automatic outs_t o_memwb();
    outs_t o = '0;
    o.regwrite = 1'b1; o.memtoreg = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_memwr(input logic be);
    outs_t o = '0;
    o.iord = 1'b1; o.memwrite = ~be; o.bus_err = be;
    return o;
  endfunction
  function automatic outs_t o_rtexec(input logic [2:0] a, input logic ill);
    outs_t o = '0;
    o.alusrca = 1'b1; o.aluc = a; o.illegal = ill;
    return o;
  endfunction
  function automatic outs_t o_rtwb();
    outs_t o = '0;
    o.regwrite = 1'b1; o.regdst = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_iexec(input logic [2:0] a, input logic ix);
    outs_t o = '0;
    o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluc = a; o.immext = ix;
    return o;
  endfunction
  function automatic outs_t o_iwb();
    outs_t o = '0;
    o.regwrite = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_branch(input logic pc);
    outs_t o = '0;
    o.alusrca = 1'b1; o.aluc = 3'b110; o.pcsrc = 2'b01; o.pcen = pc;
    return o;
  endfunction
  function automatic outs_t o_jump();
    outs_t o = '0;
    o.pcsrc = 2'b10; o.pcen = 1'b1;
    return o;
  endfunction
`ifdef MC_CONTROLLER_JAL_EN
  function automatic outs_t o_jal();
    outs_t o = '0;
    o.pcsrc = 2'b10; o.pcen = 1'b1; o.regwrite = 1'b1; o.link = 1'b1;
    return o;
  endfunction
`endif

  function automatic outs_t observe();
    outs_t o;
    o.pcen = pcen; o.iord = iord; o.irwrite = irwrite; o.memwrite = memwrite;
    o.memtoreg = memtoreg; o.regdst = regdst; o.regwrite = regwrite;
    o.alusrca = alusrca; o.alusrcb = alusrcb; o.pcsrc = pcsrc;
    o.aluc = alucontrol; o.immext = immext; o.link = link;
    o.illegal = illegal; o.bus_err = bus_err;
    return o;
  endfunction

  // Instruction builders: append one cycle-accurate step per state visited.
  function automatic void add(input logic rdy, input logic zr, input logic [5:0] o,
                              input logic [5:0] f, input outs_t e);
    step_t s;
    s.rdy = rdy; s.zr = zr; s.op = o; s.fn = f; s.e = e;
    plan.push_back(s);
  endfunction
  function automatic void add_fd(input logic [5:0] o, input logic [5:0] f, input logic ill);
    add(1'b1, 1'b0, o, f, o_fetch(1'b1, 1'b0));
    add(1'b1, 1'b0, o, f, o_decode(ill));
  endfunction
  function automatic void add_j();
    add_fd(6'b000010, 6'd0, 1'b0);
    add(1'b1, 1'b0, 6'b000010, 6'd0, o_jump());
  endfunction
  function automatic void add_rt(input logic [5:0] f, input logic [2:0] a, input logic ill);
    add_fd(6'b000000, f, 1'b0);
    add(1'b1, 1'b0, 6'b000000, f, o_rtexec(a, ill));
    add(1'b1, 1'b0, 6'b000000, f, o_rtwb());
  endfunction
  function automatic void add_it(input logic [5:0] o, input logic [2:0] a, input logic ix);
    add_fd(o, 6'd0, 1'b0);
    add(1'b1, 1'b0, o, 6'd0, o_iexec(a, ix));
    add(1'b1, 1'b0, o, 6'd0, o_iwb());
  endfunction
  function automatic void add_br(input logic [5:0] o, input logic zr, input logic pc);
    add(1'b1, zr, o, 6'd0, o_fetch(1'b1, 1'b0));
    add(1'b1, zr, o, 6'd0, o_decode(1'b0));
    add(1'b1, zr, o, 6'd0, o_branch(pc));
  endfunction
  function automatic void add_lw(input int unsigned waits, input logic tmo);
    add_fd(6'b100011, 6'd0, 1'b0);
    add(1'b1, 1'b0, 6'b100011, 6'd0, o_memadr());
    if (tmo) begin
      for (int unsigned i = 0; i < MW; i++) add(1'b0, 1'b0, 6'b100011, 6'd0, o_memrd(1'b0));
      add(1'b0, 1'b0, 6'b100011, 6'd0, o_memrd(1'b1));
    end else begin
      for (int unsigned i = 0; i < waits; i++) add(1'b0, 1'b0, 6'b100011, 6'd0, o_memrd(1'b0));
      add(1'b1, 1'b0, 6'b100011, 6'd0, o_memrd(1'b0));
      add(1'b1, 1'b0, 6'b100011, 6'd0, o_memwb());
    end
  endfunction
  function automatic void add_sw(input int unsigned waits, input logic tmo);
    add_fd(6'b101011, 6'd0, 1'b0);
    add(1'b1, 1'b0, 6'b101011, 6'd0, o_memadr());
    if (tmo) begin
      for (int unsigned i = 0; i < MW; i++) add(1'b0, 1'b0, 6'b101011, 6'd0, o_memwr(1'b0));
      add(1'b0, 1'b0, 6'b101011, 6'd0, o_memwr(1'b1));
    end else begin
      for (int unsigned i = 0; i < waits; i++) add(1'b0, 1'b0, 6'b101011, 6'd0, o_memwr(1'b0));
      add(1'b1, 1'b0, 6'b101011, 6'd0, o_memwr(1'b0));
    end
  endfunction

  // Apply one step after the edge, queue its expectation, sample mid-cycle.
  task automatic drive(input step_t s, output outs_t got);
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    op        = s.op;
    funct     = s.fn;
    zero      = s.zr;
    mem_ready = s.rdy;
    exp_q.push_back(s.e);
    @(negedge clk);
    got = observe();
  endtask

  task automatic test_reset();
    outs_t got, exp;
    step_t s;
    int    n = 0;
    reset_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; op = 6'b000010; funct = '0;
    exp_q.push_back(o_fetch(1'b0, 1'b0));
    @(negedge clk);
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset_hold: got=%h expected=%h", got, exp);
    end
    add_j();
    while (plan.size() > 0) begin
      s = plan.pop_front(); drive(s, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL reset_release step%0d: got=%h expected=%h", n, got, exp);
      end
      n++;
    end
  endtask

  task automatic test_rtype();
    outs_t got, exp;
    step_t s;
    int    n = 0;
    add_rt(6'b100000, 3'b010, 1'b0);
    add_rt(6'b100010, 3'b110, 1'b0);
    add_rt(6'b100100, 3'b000, 1'b0);
    add_rt(6'b100101, 3'b001, 1'b0);
    add_rt(6'b101010, 3'b111, 1'b0);
    add_rt(6'b000111, 3'b010, 1'b1);
    while (plan.size() > 0) begin
      s = plan.pop_front(); drive(s, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL rtype step%0d: got=%h expected=%h", n, got, exp);
      end
      n++;
    end
  endtask

  task automatic test_itype();
    outs_t got, exp;
    step_t s;
    int    n = 0;
    add_it(6'b001000, 3'b010, 1'b0);
    add_it(6'b001010, 3'b111, 1'b0);
    add_it(6'b001100, 3'b000, 1'b1);
    add_it(6'b001101, 3'b001, 1'b1);
    while (plan.size() > 0) begin
      s = plan.pop_front(); drive(s, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL itype step%0d: got=%h expected=%h", n, got, exp);
      end
      n++;
    end
  endtask

  task automatic test_branch();
    outs_t got, exp;
    step_t s;
    int    n = 0;
    add_br(6'b000100, 1'b1, 1'b1);
    add_br(6'b000100, 1'b0, 1'b0);
    add_br(6'b000101, 1'b1, 1'b0);
    add_br(6'b000101, 1'b0, 1'b1);
    while (plan.size() > 0) begin
      s = plan.pop_front(); drive(s, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL branch step%0d: got=%h expected=%h", n, got, exp);
      end
      n++;
    end
  endtask

  task automatic test_mem();
    outs_t got, exp;
    step_t s;
    int    n = 0;
    add_lw(0, 1'b0);
    add_lw(3, 1'b0);
    add_sw(0, 1'b0);
    add_lw(0, 1'b1);
    while (plan.size() > 0) begin
      s = plan.pop_front(); drive(s, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL mem step%0d: got=%h expected=%h", n, got, exp);
      end
      n++;
    end
  endtask

  task automatic test_timeout();
    outs_t got, exp;
    step_t s;
    int    n = 0;
    add_sw(0, 1'b1);
    add_sw(MW, 1'b0);
    for (int unsigned i = 0; i < MW; i++) add(1'b0, 1'b0, 6'b000010, 6'd0, o_fetch(1'b0, 1'b0));
    add(1'b0, 1'b0, 6'b000010, 6'd0, o_fetch(1'b0, 1'b1));
    add_j();
    while (plan.size() > 0) begin
      s = plan.pop_front(); drive(s, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL timeout step%0d: got=%h expected=%h", n, got, exp);
      end
      n++;
    end
  endtask

  task automatic test_illegal();
    outs_t got, exp;
    step_t s;
    int    n = 0;
    add_fd(6'b111111, 6'd0, 1'b1);
    add_fd(6'b111111, 6'd0, 1'b1);
`ifdef MC_CONTROLLER_JAL_EN
    add_fd(6'b000011, 6'd0, 1'b0);
    add(1'b1, 1'b0, 6'b000011, 6'd0, o_jal());
`else
    add_fd(6'b000011, 6'd0, 1'b1);
`endif
    add_j();
    while (plan.size() > 0) begin
      s = plan.pop_front(); drive(s, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL illegal step%0d: got=%h expected=%h", n, got, exp);
      end
      n++;
    end
  endtask

  task automatic test_reset_abort();
    outs_t got, exp;
    step_t s;
    int    n = 0;
    add_fd(6'b101011, 6'd0, 1'b0);
    add(1'b1, 1'b0, 6'b101011, 6'd0, o_memadr());
    add(1'b0, 1'b0, 6'b101011, 6'd0, o_memwr(1'b0));
    add(1'b0, 1'b0, 6'b101011, 6'd0, o_memwr(1'b0));
    while (plan.size() > 0) begin
      s = plan.pop_front(); drive(s, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL abort_pre step%0d: got=%h expected=%h", n, got, exp);
      end
      n++;
    end
    #2;
    mem_ready = 1'b1;
    reset_n   = 1'b0;
    exp_q.push_back(o_fetch(1'b0, 1'b0));
    #1;
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL abort_async: got=%h expected=%h", got, exp);
    end
    add_j();
    add_lw(1, 1'b0);
    while (plan.size() > 0) begin
      s = plan.pop_front(); drive(s, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL abort_post step%0d: got=%h expected=%h", n, got, exp);
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    outs_t      got, exp;
    step_t      s;
    int         n = 0;
    logic       zr;
    logic [5:0] rt_fn [5];
    logic [2:0] rt_alu[5];
    int unsigned k;
    rt_fn  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rt_alu = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    for (int i = 0; i < 16; i++) begin
      zr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: add_j();
        1: begin k = $urandom_range(0, 4); add_rt(rt_fn[k], rt_alu[k], 1'b0); end
        2: add_it(6'b001101, 3'b001, 1'b1);
        3: add_br(6'b000101, zr, ~zr);
        4: add_lw($urandom_range(0, 3), 1'b0);
        default: add_sw($urandom_range(0, 3), 1'b0);
      endcase
    end
    while (plan.size() > 0) begin
      s = plan.pop_front(); drive(s, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL b2b step%0d: got=%h expected=%h", n, got, exp);
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_branch();
    test_mem();
    test_timeout();
    test_illegal();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle successor to the single-cycle MIPS control unit.
- A Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles.
- Adds memory wait-state handshaking with a timeout, bne, immediate ALU ops, and illegal-opcode flagging.
- Sits between the instruction register and the shared-memory multicycle datapath.

Parameters:
- OP_W, 6: opcode field width.
- FUNCT_W, 6: funct field width.
- ALUC_W, 3: alucontrol width. Encodings occupy the low 3 bits; upper bits are 0.
- MAX_WAIT, 15: maximum cycles to wait for mem_ready before bus_err. Range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  OP_W  opcode from the instruction register.
- funct  in  FUNCT_W  funct field from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pcen  out  1  PC write enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- irwrite  out  1  instruction register write enable.
- memwrite  out  1  memory write strobe.
- memtoreg  out  1  register writeback data select: 1 = memory data.
- regdst  out  1  destination register: 1 = rd, 0 = rt.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A operand: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B operand: 00 = B, 01 = 4, 10 = immediate, 11 = immediate<<2.
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alucontrol  out  ALUC_W  ALU operation.
- immext  out  1  1 = zero-extend immediate.
- link  out  1  writeback of PC+4 to $31 (used only with JAL_EN).
- illegal  out  1  one-cycle pulse on an undecodable opcode.
- bus_err  out  1  one-cycle pulse on memory timeout.

Behaviour:
- Reset: while reset_n is low, the state is FETCH, the wait counter is 0, and all enables/strobes (pcen, irwrite, memwrite, regwrite, illegal, bus_err) are forced 0. Other outputs take their FETCH values.
- States and transitions:
  - FETCH: iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00. When mem_ready=1, pulse irwrite=1 and pcen=1 and go to DECODE; otherwise hold in FETCH.
  - DECODE: alusrca=0, alusrcb=11, alucontrol=add (branch target). Next state by op:
    - lw/sw (100011/101011) -> MEMADR.
    - R-type (000000) -> RTEXEC.
    - beq/bne (000100/000101) -> BRANCH.
    - addi/slti (001000/001010) -> IEXEC with immext=0.
    - andi/ori (001100/001101) -> IEXEC with immext=1.
    - j (000010) -> JUMP.
    - Any other op: pulse illegal and go to FETCH.
  - MEMADR: alusrca=1, alusrcb=10, alucontrol=add. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD: iord=1. When mem_ready=1, go to MEMWB.
  - MEMWB: regwrite=1, memtoreg=1, regdst=0. Go to FETCH.
  - MEMWR: iord=1, memwrite=1 every cycle the state is held. When mem_ready=1, go to FETCH.
  - RTEXEC: alusrca=1, alusrcb=00, alucontrol from funct:
    - 100000 -> 010 (add); 100010 -> 110 (sub); 100100 -> 000 (and); 100101 -> 001 (or); 101010 -> 111 (slt).
    - Other funct values -> 010 and pulse illegal.
    - Go to RTWB.
  - RTWB: regwrite=1, regdst=1, memtoreg=0. Go to FETCH.
  - IEXEC: alusrca=1, alusrcb=10, alucontrol = add/slt/and/or per op, immext per op. Go to IWB.
  - IWB: regwrite=1, regdst=0, memtoreg=0. Go to FETCH.
  - BRANCH: alusrca=1, alusrcb=00, alucontrol=sub, pcsrc=01. pcen=zero for beq, pcen=~zero for bne. Go to FETCH.
  - JUMP: pcsrc=10, pcen=1. Go to FETCH.
- Output defaults: all outputs not listed for a state are 0.
- Outputs are pure functions of state plus op/funct/zero. There is no output register and no added latency.
- Instruction latencies (with mem_ready=1 on every memory cycle):
  - j: 3 cycles.
  - beq/bne: 3 cycles.
  - R-type and immediate ops: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle the FSM holds in one of those states with mem_ready=0.
  - If it reaches MAX_WAIT with mem_ready still 0: pulse bus_err for one cycle, go to FETCH, and suppress that cycle's memwrite/irwrite/pcen.
  - mem_ready=1 in the same cycle as the count reaching MAX_WAIT means success, not an error.
- An asynchronous reset_n assertion mid-instruction aborts it immediately; no partial register or memory write completes after the assertion edge.

Optional Feature:
- Macro: MC_CONTROLLER_JAL_EN.
- When defined:
  - op 000011 (jal) goes DECODE -> JAL.
  - JAL: pcsrc=10, pcen=1, regwrite=1, link=1 (datapath writes PC+4 to $31). Go to FETCH. Latency 3 cycles.
- When undefined: link is tied to 0 and op 000011 is treated as illegal.

Test Plan:
- Release reset_n with mem_ready=1 -> first cycle FETCH with irwrite=1, pcen=1, alusrcb=01, alucontrol=010; DECODE on the next cycle.
- add (op=000000, funct=100000) -> RTEXEC with alucontrol=010, then RTWB with regwrite=1, regdst=1; back to FETCH after 4 cycles.
- beq with zero=1 -> pcen=1, pcsrc=01 in BRANCH. bne with zero=1 -> pcen=0. bne with zero=0 -> pcen=1.
- lw with mem_ready held low 3 cycles in MEMRD -> FSM stays in MEMRD with iord=1; MEMWB regwrite=1, memtoreg=1; total 8 cycles.
- sw with mem_ready never asserted, MAX_WAIT=15 -> bus_err pulses after 15 wait cycles, memwrite=0 in that cycle, FSM returns to FETCH.
- op=111111 -> illegal pulses in DECODE, no regwrite. With MC_CONTROLLER_JAL_EN, op=000011 -> JAL with link=1, regwrite=1, pcen=1.
